// File: rtl/simd_host_sequencer.sv
// simd_host_sequencer: host-loaded N x 32 instruction memory plus IDLE/RUN/DONE run control for a SIMD core.
// Latency: INSTR_AXI is registered (1 cycle after PC_AXI); status outputs are registered and update on the edge after their cause.
// Backpressure: none; host writes during RUN and HOST_START during RUN are dropped. Optional watchdog: define SEQ_TIMEOUT_EN.
module simd_host_sequencer #(
  parameter int          N              = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int         AW             = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HOST_WE,
  input  logic [AW-1:0] HOST_WADDR,
  input  logic [31:0]   HOST_WDATA,
  input  logic          HOST_START,
  input  logic          HOST_CLR,
  output logic          HOST_BUSY,
  output logic          HOST_DONE,
  output logic          ERR_TIMEOUT,
  output logic [31:0]   CYCLE_COUNT,
  input  logic [AW-1:0] PC_AXI,
  output logic [31:0]   INSTR_AXI,
  output logic          START_SIGNAL,
  input  logic          STOP_SIGNAL
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      r_state;
  logic        r_first;
  logic [31:0] r_cnt;
  logic        r_start;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_instr;
  logic [31:0] r_mem [N];

  logic        w_we_ok;
  logic        w_stop_ok;
  logic [31:0] w_cnt_next;

  // Host may only rewrite the program while the core is not running; reset also blocks writes.
  assign w_we_ok    = HOST_WE && (r_state != ST_RUN) && !RST;
  // A stop still asserted from the previous run is ignored in the first RUN cycle.
  assign w_stop_ok  = STOP_SIGNAL && !r_first;
  assign w_cnt_next = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_we_ok) begin
      r_mem[HOST_WADDR] <= HOST_WDATA;
    end
  end

  // Registered core read port; same-address write in the same cycle returns the old word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr <= 32'd0;
    end else begin
      r_instr <= r_mem[PC_AXI];
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic r_err;

  // Run-control FSM with watchdog; outputs are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
      r_cnt   <= 32'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (HOST_CLR) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (HOST_START) begin
            r_state <= ST_RUN;
            r_first <= 1'b1;
            r_cnt   <= 32'd0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end else if (HOST_CLR && (r_state == ST_DONE)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_first <= 1'b0;
          r_cnt   <= w_cnt_next;
          // An accepted stop outranks a simultaneous watchdog expiry.
          if (w_stop_ok) begin
            r_state <= ST_DONE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_cnt_next == TIMEOUT_CYCLES) begin
            r_state <= ST_DONE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ERR_TIMEOUT = r_err;
`else
  // Run-control FSM; a run ends only on an accepted stop or reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
      r_cnt   <= 32'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (HOST_CLR) begin
        r_done <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (HOST_START) begin
            r_state <= ST_RUN;
            r_first <= 1'b1;
            r_cnt   <= 32'd0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else if (HOST_CLR && (r_state == ST_DONE)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_first <= 1'b0;
          r_cnt   <= w_cnt_next;
          if (w_stop_ok) begin
            r_state <= ST_DONE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ERR_TIMEOUT = 1'b0;
`endif

  assign HOST_BUSY    = r_busy;
  assign HOST_DONE    = r_done;
  assign CYCLE_COUNT  = r_cnt;
  assign START_SIGNAL = r_start;
  assign INSTR_AXI    = r_instr;

endmodule

// File: tb/tb_simd_host_sequencer.sv
// Directed bench for simd_host_sequencer: load/readback, normal and stale-stop runs,
// write protect, start/clear interactions, long run (watchdog when SEQ_TIMEOUT_EN), mid-run reset.
module tb_simd_host_sequencer;

  localparam int AW = 9;

  logic          CLK = 1'b0;
  logic          RST;
  logic          HOST_WE;
  logic [AW-1:0] HOST_WADDR;
  logic [31:0]   HOST_WDATA;
  logic          HOST_START;
  logic          HOST_CLR;
  logic          HOST_BUSY;
  logic          HOST_DONE;
  logic          ERR_TIMEOUT;
  logic [31:0]   CYCLE_COUNT;
  logic [AW-1:0] PC_AXI;
  logic [31:0]   INSTR_AXI;
  logic          START_SIGNAL;
  logic          STOP_SIGNAL;

  int checks   = 0;
  int failures = 0;

  simd_host_sequencer #(.N(512), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .HOST_WE(HOST_WE), .HOST_WADDR(HOST_WADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_START(HOST_START), .HOST_CLR(HOST_CLR),
    .HOST_BUSY(HOST_BUSY), .HOST_DONE(HOST_DONE), .ERR_TIMEOUT(ERR_TIMEOUT),
    .CYCLE_COUNT(CYCLE_COUNT), .PC_AXI(PC_AXI), .INSTR_AXI(INSTR_AXI),
    .START_SIGNAL(START_SIGNAL), .STOP_SIGNAL(STOP_SIGNAL)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; HOST_WE = 1'b0; HOST_WADDR = '0; HOST_WDATA = '0;
    HOST_START = 1'b0; HOST_CLR = 1'b0; PC_AXI = '0; STOP_SIGNAL = 1'b0;
    tick(2);
    chk("rst_busy",  {31'd0, HOST_BUSY},    32'd0);
    chk("rst_done",  {31'd0, HOST_DONE},    32'd0);
    chk("rst_err",   {31'd0, ERR_TIMEOUT},  32'd0);
    chk("rst_start", {31'd0, START_SIGNAL}, 32'd0);
    chk("rst_count", CYCLE_COUNT,           32'd0);
    chk("rst_instr", INSTR_AXI,             32'd0);
    RST = 1'b0;

    // Load addresses 3, 5, 7 in IDLE.
    HOST_WE = 1'b1; HOST_WADDR = 9'd3; HOST_WDATA = 32'hA5A5_0001; tick();
    HOST_WADDR = 9'd5; HOST_WDATA = 32'h1111_1111; tick();
    HOST_WADDR = 9'd7; HOST_WDATA = 32'h2222_2222; tick();
    HOST_WE = 1'b0; PC_AXI = 9'd3; tick();
    chk("load_rd3", INSTR_AXI, 32'hA5A5_0001);

    // Same-address read and write in one cycle returns old data.
    PC_AXI = 9'd7; HOST_WE = 1'b1; HOST_WADDR = 9'd7; HOST_WDATA = 32'h3333_3333; tick();
    chk("raw_old", INSTR_AXI, 32'h2222_2222);
    HOST_WE = 1'b0; tick();
    chk("raw_new", INSTR_AXI, 32'h3333_3333);

    // Normal run: stop raised in RUN cycle 10.
    HOST_START = 1'b1; tick(); HOST_START = 1'b0;
    chk("run_start", {31'd0, START_SIGNAL}, 32'd1);
    chk("run_busy",  {31'd0, HOST_BUSY},    32'd1);
    chk("run_cnt0",  CYCLE_COUNT,           32'd0);
    tick(9);
    chk("run_c9_start", {31'd0, START_SIGNAL}, 32'd1);
    chk("run_c9_cnt",   CYCLE_COUNT,           32'd9);
    STOP_SIGNAL = 1'b1; tick();
    chk("run_end_start", {31'd0, START_SIGNAL}, 32'd0);
    chk("run_end_busy",  {31'd0, HOST_BUSY},    32'd0);
    chk("run_end_done",  {31'd0, HOST_DONE},    32'd1);
    chk("run_end_cnt",   CYCLE_COUNT,           32'd10);
    tick(3);
    chk("done_frozen", CYCLE_COUNT,           32'd10);
    chk("done_sticky", {31'd0, HOST_DONE},    32'd1);

    // Stale stop held high across a new start: RUN lasts exactly 2 cycles.
    HOST_START = 1'b1; tick(); HOST_START = 1'b0;
    chk("stale_busy", {31'd0, HOST_BUSY}, 32'd1);
    chk("stale_done_clr", {31'd0, HOST_DONE}, 32'd0);
    tick();
    chk("stale_c1_busy", {31'd0, HOST_BUSY}, 32'd1);
    tick();
    chk("stale_end_start", {31'd0, START_SIGNAL}, 32'd0);
    chk("stale_end_done",  {31'd0, HOST_DONE},    32'd1);
    chk("stale_end_cnt",   CYCLE_COUNT,           32'd2);
    STOP_SIGNAL = 1'b0;

    // HOST_CLR in DONE clears the flag and returns to IDLE.
    HOST_CLR = 1'b1; tick(); HOST_CLR = 1'b0;
    chk("clr_done", {31'd0, HOST_DONE}, 32'd0);

    // Write protect during RUN, and HOST_START ignored in RUN.
    HOST_START = 1'b1; tick(); HOST_START = 1'b0;
    HOST_WE = 1'b1; HOST_WADDR = 9'd5; HOST_WDATA = 32'hDEAD_BEEF; tick(); HOST_WE = 1'b0;
    HOST_START = 1'b1; tick(); HOST_START = 1'b0;
    chk("start_ignored_cnt", CYCLE_COUNT, 32'd2);
    STOP_SIGNAL = 1'b1; tick(); STOP_SIGNAL = 1'b0;
    chk("wp_run_cnt", CYCLE_COUNT, 32'd3);
    PC_AXI = 9'd5; tick();
    chk("wp_addr5", INSTR_AXI, 32'h1111_1111);

    // START with CLR in DONE: start wins. Then a long run with stop low.
    HOST_START = 1'b1; HOST_CLR = 1'b1; tick(); HOST_START = 1'b0; HOST_CLR = 1'b0;
    chk("prec_busy", {31'd0, HOST_BUSY}, 32'd1);
    chk("prec_done", {31'd0, HOST_DONE}, 32'd0);
    tick(20);
`ifdef SEQ_TIMEOUT_EN
    chk("wd_err",   {31'd0, ERR_TIMEOUT},  32'd1);
    chk("wd_done",  {31'd0, HOST_DONE},    32'd1);
    chk("wd_start", {31'd0, START_SIGNAL}, 32'd0);
    chk("wd_cnt",   CYCLE_COUNT,           32'd16);
    HOST_CLR = 1'b1; tick(); HOST_CLR = 1'b0;
    chk("wd_err_clr", {31'd0, ERR_TIMEOUT}, 32'd0);
`else
    chk("long_busy", {31'd0, HOST_BUSY},   32'd1);
    chk("long_err",  {31'd0, ERR_TIMEOUT}, 32'd0);
    chk("long_cnt",  CYCLE_COUNT,          32'd20);
    STOP_SIGNAL = 1'b1; tick(); STOP_SIGNAL = 1'b0;
    chk("long_end_cnt",  CYCLE_COUNT,        32'd21);
    chk("long_end_done", {31'd0, HOST_DONE}, 32'd1);
`endif

    // Write and start in the same cycle: both take effect. Then reset in RUN cycle 4.
    HOST_WE = 1'b1; HOST_WADDR = 9'd9; HOST_WDATA = 32'h4444_4444; HOST_START = 1'b1; tick();
    HOST_WE = 1'b0; HOST_START = 1'b0;
    chk("we_start_busy", {31'd0, HOST_BUSY}, 32'd1);
    tick(3);
    chk("mid_c3_cnt", CYCLE_COUNT, 32'd3);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("mid_rst_start", {31'd0, START_SIGNAL}, 32'd0);
    chk("mid_rst_done",  {31'd0, HOST_DONE},    32'd0);
    chk("mid_rst_busy",  {31'd0, HOST_BUSY},    32'd0);
    chk("mid_rst_cnt",   CYCLE_COUNT,           32'd0);
    PC_AXI = 9'd9; tick();
    chk("mem_keep9", INSTR_AXI, 32'h4444_4444);
    PC_AXI = 9'd3; tick();
    chk("mem_keep3", INSTR_AXI, 32'hA5A5_0001);
    tick(2);
    chk("idle_after_rst", {31'd0, HOST_BUSY}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
